// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults, ID width helper and response record for the mac_mul arbiter
// Contents:
//   *_DEF   default requester count, operand/product widths, multiplier latency, FIFO depth
//   id_w    requester-ID width, max(1, clog2(n))
//   rsp_t   {id, val} response record at the default widths
package mac_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int INPUT_WIDTH_DEF = 16;
  localparam int OUTPUT_WIDTH_DEF = 32;
  localparam int MUL_LATENCY_DEF = 7;
  localparam int FIFO_DEPTH_DEF = 8;
  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  localparam int ID_W_DEF = id_w(NUM_REQ_DEF);
  typedef struct packed {
    logic [ID_W_DEF-1:0] id;
    logic [OUTPUT_WIDTH_DEF-1:0] val;
  } rsp_t;
endpackage

// File: rtl/mac_mul.sv
// mac_mul: fixed-latency pipelined multiplier without stall
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_a, i_b          operands
//   i_valid           operand valid
//   o_val, o_valid    product and its valid, LATENCY cycles after i_valid
module mac_mul
  import mac_pkg::*;
#(
  parameter int INPUT_WIDTH = INPUT_WIDTH_DEF,
  parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
  parameter int LATENCY = MUL_LATENCY_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [INPUT_WIDTH-1:0]  i_a,
  input  logic [INPUT_WIDTH-1:0]  i_b,
  input  logic                    i_valid,
  output logic [OUTPUT_WIDTH-1:0] o_val,
  output logic                    o_valid
);
  logic [OUTPUT_WIDTH-1:0] p [LATENCY];
  logic [LATENCY-1:0] v;
  // Only the valid bits are reset; a reset therefore discards every product in flight.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) v <= '0;
    else v <= {v[LATENCY-2:0], i_valid};
  always_ff @(posedge i_clk) begin
    p[0] <= OUTPUT_WIDTH'(i_a) * OUTPUT_WIDTH'(i_b);
    for (int i = 1; i < LATENCY; i++) p[i] <= p[i-1];
  end
  assign o_val = p[LATENCY-1];
  assign o_valid = v[LATENCY-1];
endmodule

// File: rtl/mac_rsp_fifo.sv
// mac_rsp_fifo: synchronous FIFO with asynchronous reset and full/empty flags
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push, din    write request and data; accepted when not full or when popping in the same cycle
//   pop, dout    read request and head-of-queue data (dout is meaningful only when !empty)
//   full, empty  occupancy flags
module mac_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic wen, ren;
  // Pointers carry one extra wrap bit so full and empty are told apart without a counter.
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign ren = pop && !empty;
  assign wen = push && (!full || ren);
  assign dout = mem[rd[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      wr <= wr + (AW+1)'(wen);
      rd <= rd + (AW+1)'(ren);
    end
  always_ff @(posedge clk)
    if (wen) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/mac_mul_arb.sv
// mac_mul_arb: round-robin arbiter sharing one pipelined mac_mul among NUM_REQ requesters
// Ports:
//   i_clk, i_rst               clock, asynchronous active-high reset
//   i_req_valid/a/b            per-requester operand pairs, requester k in slice k
//   o_req_ready                one-hot grant, transfer on valid & ready
//   o_mul_a/b/valid            registered issue to the multiplier
//   i_mul_val/valid            product returning from the multiplier
//   o_rsp_valid/val/id         tagged response from the FIFO, consumed on valid & i_rsp_ready
//   o_busy                     issue in flight or FIFO not empty
//   o_err                      sticky: product valid disagreed with the tag pipe
module mac_mul_arb
  import mac_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int INPUT_WIDTH = INPUT_WIDTH_DEF,
  parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] i_req_a,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] i_req_b,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic [INPUT_WIDTH-1:0]         o_mul_a,
  output logic [INPUT_WIDTH-1:0]         o_mul_b,
  output logic                           o_mul_valid,
  input  logic [OUTPUT_WIDTH-1:0]        i_mul_val,
  input  logic                           i_mul_valid,
  output logic                           o_rsp_valid,
  output logic [OUTPUT_WIDTH-1:0]        o_rsp_val,
  output logic [id_w(NUM_REQ)-1:0]       o_rsp_id,
  input  logic                           i_rsp_ready,
  output logic                           o_busy,
  output logic                           o_err
);
  localparam int ID_W = id_w(NUM_REQ);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [OUTPUT_WIDTH-1:0] val;
  } entry_t;
  logic [INPUT_WIDTH-1:0] req_a [NUM_REQ];
  logic [INPUT_WIDTH-1:0] req_b [NUM_REQ];
  logic [ID_W-1:0] ptr, idx, gnt_id, iss_id;
  logic [ID_W-1:0] tag_id [MUL_LATENCY];
  logic [MUL_LATENCY-1:0] tag_v;
  logic [CW-1:0] credits;
  logic found, gnt, push, pop, empty, full_unused, err;
  entry_t din, dout;
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign req_a[k] = i_req_a[k*INPUT_WIDTH +: INPUT_WIDTH];
    assign req_b[k] = i_req_b[k*INPUT_WIDTH +: INPUT_WIDTH];
  end
  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && i_req_valid[idx]) begin
        found = 1'b1;
        gnt_id = idx;
      end
    end
  end
  // Each credit stands for one FIFO slot that nothing in flight has claimed yet.
  // With no credit left, a grant could overflow the FIFO, because the multiplier cannot stall.
  assign gnt = found && (credits != '0);
  assign o_req_ready = gnt ? NUM_REQ'(1) << gnt_id : '0;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      ptr <= '0;
      o_mul_valid <= 1'b0;
      o_mul_a <= '0;
      o_mul_b <= '0;
      iss_id <= '0;
      credits <= CW'(FIFO_DEPTH);
      tag_v <= '0;
      err <= 1'b0;
    end else begin
      ptr <= gnt ? ((gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1) : ptr;
      o_mul_valid <= gnt;
      o_mul_a <= gnt ? req_a[gnt_id] : '0;
      o_mul_b <= gnt ? req_b[gnt_id] : '0;
      iss_id <= gnt ? gnt_id : '0;
      credits <= credits - CW'(gnt) + CW'(pop);
      tag_v <= {tag_v[MUL_LATENCY-2:0], o_mul_valid};
      err <= err | (i_mul_valid != tag_v[MUL_LATENCY-1]);
    end
  // The tag pipe is fed from the issue register, so its last stage lines up with i_mul_valid.
  // IDs need no reset because tag_v qualifies them.
  always_ff @(posedge i_clk) begin
    tag_id[0] <= iss_id;
    for (int i = 1; i < MUL_LATENCY; i++) tag_id[i] <= tag_id[i-1];
  end
  // A product arriving without a matching tag is dropped; it never took a FIFO slot, so it returns no credit.
  assign push = i_mul_valid & tag_v[MUL_LATENCY-1];
  assign pop = o_rsp_valid & i_rsp_ready;
  assign din = '{id: tag_id[MUL_LATENCY-1], val: i_mul_val};
  mac_rsp_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .push(push),
    .din(din),
    .pop(pop),
    .dout(dout),
    .full(full_unused),
    .empty(empty)
  );
  // Response fields read 0 while the FIFO is empty, so reset leaves every output at 0.
  assign o_rsp_valid = !empty;
  assign o_rsp_val = empty ? '0 : dout.val;
  assign o_rsp_id = empty ? '0 : dout.id;
  assign o_busy = o_mul_valid | (|tag_v) | !empty;
  assign o_err = err;
endmodule

// File: tb/tb_mac_mul_arb.sv
// tb_mac_mul_arb: directed self-checking bench for mac_mul_arb driving a real mac_mul
module tb_mac_mul_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [3:0] req_ready;
  logic [15:0] mul_a, mul_b;
  logic mul_v_in, mul_valid_w;
  logic [31:0] mul_p;
  logic rsp_valid, rsp_ready = 1'b0, busy, err;
  logic [31:0] rsp_val;
  logic [1:0] rsp_id;
  logic f_push = 1'b0, f_pop = 1'b0, f_full, f_empty;
  logic [7:0] f_din = '0, f_dout;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mac_mul_arb #(.NUM_REQ(4), .INPUT_WIDTH(16), .OUTPUT_WIDTH(32), .MUL_LATENCY(7), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b),
    .o_req_ready(req_ready), .o_mul_a(mul_a), .o_mul_b(mul_b), .o_mul_valid(mul_v_in),
    .i_mul_val(mul_p), .i_mul_valid(mul_valid_w), .o_rsp_valid(rsp_valid), .o_rsp_val(rsp_val),
    .o_rsp_id(rsp_id), .i_rsp_ready(rsp_ready), .o_busy(busy), .o_err(err)
  );

  mac_mul #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(32), .LATENCY(7)) mul (
    .i_clk(clk), .i_rst(rst), .i_a(mul_a), .i_b(mul_b), .i_valid(mul_v_in),
    .o_val(mul_p), .o_valid(mul_valid_w)
  );

  mac_rsp_fifo #(.WIDTH(8), .DEPTH(4)) fifo (
    .clk(clk), .rst(rst), .push(f_push), .din(f_din), .pop(f_pop),
    .dout(f_dout), .full(f_full), .empty(f_empty)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    f_push = 1'b0;
    f_pop = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic load_ops();
    for (int k = 0; k < 4; k++) begin
      req_a[k*16 +: 16] = 16'(k + 1);
      req_b[k*16 +: 16] = 16'(k + 10);
    end
  endtask

  task automatic test_reset();
    req_valid = '0;
    rst = 1'b1;
    #2;
    total++;
    if (((|req_ready) | mul_v_in | (|mul_a) | (|mul_b) | rsp_valid | (|rsp_val) | (|rsp_id) | busy | err) !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b mv=%b rv=%b busy=%b err=%b, all must be 0", req_ready, mul_v_in, rsp_valid, busy, err);
    end
    total++;
    if (f_empty !== 1'b1) begin bad++; $display("FAIL reset_fifo_empty: got %b exp 1", f_empty); end
    cyc();
    cyc();
    rst = 1'b0;
    req_valid = 4'b1010;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL reset_ptr_zero: got %b exp 0010", req_ready); end
    req_valid = '0;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL idle_no_grant: got %b exp 0000", req_ready); end
  endtask

  task automatic test_single();
    apply_reset();
    rsp_ready = 1'b1;
    req_a[32 +: 16] = 16'd3;
    req_b[32 +: 16] = 16'd5;
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b exp 0100", req_ready); end
    for (int n = 1; n <= 9; n++) begin
      cyc();
      if (n == 1) begin
        req_valid = '0;
        total++;
        if ({mul_v_in, mul_a, mul_b} !== {1'b1, 16'd3, 16'd5}) begin
          bad++;
          $display("FAIL single_issue: got v=%b a=%0d b=%0d exp v=1 a=3 b=5", mul_v_in, mul_a, mul_b);
        end
      end
      if (n == 2) begin
        total++;
        if ({mul_v_in, mul_a, mul_b} !== 33'd0) begin
          bad++;
          $display("FAIL single_issue_clear: got v=%b a=%0d b=%0d exp all 0", mul_v_in, mul_a, mul_b);
        end
      end
      if (n == 8) begin
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early: rsp_valid=%b at T+8 exp 0", rsp_valid); end
      end
      if (n == 9) begin
        total++;
        if ({rsp_valid, rsp_val, rsp_id} !== {1'b1, 32'd15, 2'd2}) begin
          bad++;
          $display("FAIL single_rsp: got v=%b val=%0d id=%0d exp v=1 val=15 id=2", rsp_valid, rsp_val, rsp_id);
        end
      end
    end
    cyc();
    total++;
    if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL single_drain: got v=%b busy=%b exp 0 0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin();
    int ri;
    int e;
    logic [3:0] exp;
    logic expv;
    apply_reset();
    load_ops();
    rsp_ready = 1'b1;
    ri = 0;
    for (int c = 0; c < 26; c++) begin
      req_valid = (c < 14) ? 4'hF : 4'h0;
      #1;
      exp = (c < 4) ? 4'(1 << c) : (c >= 10 && c < 14) ? 4'(1 << (c - 10)) : 4'h0;
      expv = (c >= 9 && c <= 12) || (c >= 19 && c <= 22);
      total++;
      if (req_ready !== exp) begin bad++; $display("FAIL rr_grant c=%0d: got %b exp %b", c, req_ready, exp); end
      total++;
      if (rsp_valid !== expv) begin bad++; $display("FAIL rr_rsp_valid c=%0d: got %b exp %b", c, rsp_valid, expv); end
      if (rsp_valid) begin
        e = ri % 4;
        total++;
        if ({rsp_id, rsp_val} !== {2'(e), 32'((e + 1) * (e + 10))}) begin
          bad++;
          $display("FAIL rr_rsp #%0d: got id=%0d val=%0d exp id=%0d val=%0d", ri, rsp_id, rsp_val, e, (e + 1) * (e + 10));
        end
        ri++;
      end
      cyc();
    end
    total++;
    if (ri !== 8) begin bad++; $display("FAIL rr_count: got %0d exp 8", ri); end
    total++;
    if ({err, busy} !== 2'b00) begin bad++; $display("FAIL rr_idle: err=%b busy=%b exp 0 0", err, busy); end
  endtask

  task automatic test_backpressure();
    int ri;
    int e;
    int ids [4];
    logic [3:0] exp;
    ids = '{2, 3, 0, 1};
    apply_reset();
    load_ops();
    for (int c = 0; c < 22; c++) begin
      req_valid = 4'hF;
      rsp_ready = (c == 16) || (c == 19);
      #1;
      exp = (c < 4) ? 4'(1 << c) : (c == 17) ? 4'b0001 : (c == 20) ? 4'b0010 : 4'h0;
      total++;
      if (req_ready !== exp) begin bad++; $display("FAIL bp_grant c=%0d: got %b exp %b", c, req_ready, exp); end
      if (c == 15) begin
        total++;
        if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_fifo_held: rsp_valid=%b exp 1", rsp_valid); end
      end
      if (c == 16) begin
        total++;
        if ({rsp_id, rsp_val} !== {2'd0, 32'd10}) begin bad++; $display("FAIL bp_pop0: got id=%0d val=%0d exp 0 10", rsp_id, rsp_val); end
      end
      if (c == 19) begin
        total++;
        if ({rsp_id, rsp_val} !== {2'd1, 32'd22}) begin bad++; $display("FAIL bp_pop1: got id=%0d val=%0d exp 1 22", rsp_id, rsp_val); end
      end
      cyc();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    ri = 0;
    for (int n = 0; n < 30; n++) begin
      #1;
      if (rsp_valid) begin
        e = (ri < 4) ? ids[ri] : 0;
        total++;
        if ({rsp_id, rsp_val} !== {2'(e), 32'((e + 1) * (e + 10))}) begin
          bad++;
          $display("FAIL bp_drain #%0d: got id=%0d val=%0d exp id=%0d val=%0d", ri, rsp_id, rsp_val, e, (e + 1) * (e + 10));
        end
        ri++;
      end
      cyc();
    end
    total++;
    if (ri !== 4) begin bad++; $display("FAIL bp_count: got %0d exp 4", ri); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle: busy=%b exp 0", busy); end
  endtask

  task automatic test_max_operands();
    logic got;
    apply_reset();
    rsp_ready = 1'b1;
    req_a[48 +: 16] = 16'hFFFF;
    req_b[48 +: 16] = 16'hFFFF;
    req_valid = 4'b1000;
    cyc();
    req_valid = '0;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (rsp_valid) begin
        got = 1'b1;
        total++;
        if ({rsp_id, rsp_val} !== {2'd3, 32'hFFFE0001}) begin
          bad++;
          $display("FAIL max_rsp: got id=%0d val=%h exp id=3 val=fffe0001", rsp_id, rsp_val);
        end
        break;
      end
      cyc();
    end
    total++;
    if (got !== 1'b1) begin bad++; $display("FAIL max_timeout: rsp_valid=%b exp 1 within 20 cycles", got); end
  endtask

  task automatic test_fifo_full();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      f_din = 8'(11 * (i + 1));
      f_push = 1'b1;
      cyc();
    end
    f_push = 1'b0;
    total++;
    if ({f_full, f_empty, f_dout} !== {1'b1, 1'b0, 8'd11}) begin
      bad++;
      $display("FAIL fifo_fill: got full=%b empty=%b dout=%0d exp 1 0 11", f_full, f_empty, f_dout);
    end
    f_din = 8'd55;
    f_push = 1'b1;
    f_pop = 1'b1;
    cyc();
    f_push = 1'b0;
    f_pop = 1'b0;
    total++;
    if ({f_full, f_dout} !== {1'b1, 8'd22}) begin
      bad++;
      $display("FAIL fifo_full_pushpop: got full=%b dout=%0d exp 1 22", f_full, f_dout);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (f_dout !== 8'(22 + 11 * i)) begin bad++; $display("FAIL fifo_order %0d: got %0d exp %0d", i, f_dout, 22 + 11 * i); end
      f_pop = 1'b1;
      cyc();
      f_pop = 1'b0;
    end
    total++;
    if (f_empty !== 1'b1) begin bad++; $display("FAIL fifo_empty: got %b exp 1", f_empty); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    load_ops();
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    cyc();
    cyc();
    cyc();
    req_valid = '0;
    cyc();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_inflight: busy=%b exp 1", busy); end
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ((mul_v_in | (|mul_a) | (|mul_b) | rsp_valid | (|rsp_val) | busy | err | (|req_ready)) !== 1'b0) begin
      bad++;
      $display("FAIL mid_async_clear: mv=%b rv=%b busy=%b ready=%b exp all 0", mul_v_in, rsp_valid, busy, req_ready);
    end
    cyc();
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      cyc();
      total++;
      if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL mid_stale c=%0d: rsp_valid=%b busy=%b exp 0 0", n, rsp_valid, busy); end
    end
  endtask

  task automatic test_error();
    apply_reset();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_clear_start: got %b exp 0", err); end
    force mul_valid_w = 1'b1;
    cyc();
    release mul_valid_w;
    for (int n = 0; n < 5; n++) begin
      total++;
      if ({err, rsp_valid} !== 2'b10) begin bad++; $display("FAIL err_sticky c=%0d: err=%b rsp_valid=%b exp 1 0", n, err, rsp_valid); end
      cyc();
    end
    rst = 1'b1;
    #1;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_reset: got %b exp 0", err); end
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_max_operands();
    test_fifo_full();
    test_reset_mid();
    test_error();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
